ddr_ring_sched: RTL and testbench
=================================

Name: ddr_ring_sched

Overview:
- Sequences the AXI DataMover so ADC capture streams continuously into a circular DDR3 buffer of NUM_SEG fixed-size segments.
- Reads back the oldest committed segment on request, for the slow Ethernet drain.
- Owns both DataMover command channels (S2MM, MM2S) and both status channels, tracks ring occupancy, and halts on any DataMover error.
- Sits between the capture/readback glue and the DataMover inside the system block diagram.

Parameters:
- BASE_ADDR, 32'h0000_0000, DDR byte address of segment 0.
- SEG_BYTES, 4096, bytes per segment; becomes BTT; multiple of 8; at most 2^23-1.
- NUM_SEG, 16, number of ring segments; power of 2, range 2..256.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- enable  in  1  capture run; 1 = keep issuing S2MM segments.
- rd_req  in  1  single-cycle pulse; read out the oldest committed segment.
- m_axis_s2mm_cmdsts_aresetn  out  1  registered ~reset.
- S_AXIS_S2MM_CMD_tdata  out  72  S2MM command.
- S_AXIS_S2MM_CMD_tvalid  out  1.
- S_AXIS_S2MM_CMD_tready  in  1.
- M_AXIS_S2MM_STS_tdata  in  8  S2MM status.
- M_AXIS_S2MM_STS_tvalid  in  1.
- M_AXIS_S2MM_STS_tready  out  1.
- m_axis_mm2s_cmdsts_aresetn  out  1  registered ~reset.
- S_AXIS_MM2S_CMD_tdata  out  72  MM2S command.
- S_AXIS_MM2S_CMD_tvalid  out  1.
- S_AXIS_MM2S_CMD_tready  in  1.
- M_AXIS_MM2S_STS_tdata  in  8  MM2S status.
- M_AXIS_MM2S_STS_tvalid  in  1.
- M_AXIS_MM2S_STS_tready  out  1.
- fill  out  clog2(NUM_SEG)+1  committed, unread segments.
- rd_busy  out  1  MM2S transfer in flight.
- full_stall  out  1  S2MM held off because the ring is full.
- err  out  1  sticky error.
- err_status  out  8  first failing status byte.

Behaviour:
- **Reset** (synchronous): all outputs go to 0 during reset, including both cmd tvalid/tdata, both sts tready, both aresetn, fill, err and err_status. Internal wr_seg, rd_seg and both FSMs go to IDLE. From the first cycle after reset: both aresetn = 1 and both sts tready = 1. Reset mid-transfer abandons it; nothing is preserved.
- **Command format**, both channels: {4'h0, tag[3:0], addr[31:0], 8'h00, 1'b1, btt[22:0]}.
  - btt = SEG_BYTES.
  - addr = BASE_ADDR + seg*SEG_BYTES, in 32-bit arithmetic.
  - tag = seg[3:0].
- **Status byte**: [7] OKAY, [6] SLVERR, [5] DECERR, [4] INTERR, [3:0] TAG. A status is good only if [7]=1, [6:4]=0 and TAG equals the tag of the outstanding command.
- **S2MM FSM** (W_IDLE, W_CMD, W_WAIT):
  - W_IDLE -> W_CMD when enable && fill < NUM_SEG && !err. tdata is registered with wr_seg; tvalid is asserted the next cycle.
  - W_CMD: hold tvalid and tdata stable until tready. On tvalid&&tready: tvalid drops, go to W_WAIT.
  - W_WAIT: on sts tvalid with good status: wr_seg <= wr_seg+1 (mod NUM_SEG), fill increments, go to W_IDLE. The earliest next command is 1 cycle later.
  - full_stall = (W_IDLE && enable && fill == NUM_SEG).
  - enable deasserted in W_CMD or W_WAIT: the command completes normally, then the FSM stays in W_IDLE.
- **MM2S FSM** (R_IDLE, R_CMD, R_WAIT):
  - R_IDLE: rd_req with fill > 0 && !err -> R_CMD using rd_seg. rd_req while fill == 0, not in R_IDLE, or with err set is dropped (no queueing).
  - R_CMD: same handshake rules as S2MM.
  - R_WAIT: on good status: rd_seg <= rd_seg+1 (mod NUM_SEG), fill decrements, go to R_IDLE.
  - rd_busy = !R_IDLE.
  - A segment being read stays counted in fill until its status returns, so S2MM can never overwrite it.
- **Simultaneous S2MM commit and MM2S retire** in the same cycle: fill unchanged, both pointers advance.
- **Bad status** on either channel:
  - err <= 1 and err_status <= the failing byte (first error only; a later error does not overwrite).
  - Both FSMs return to IDLE and issue nothing further.
  - fill and pointers are frozen. Only reset clears the error.
- **Stray status** (sts tvalid while that FSM is not in WAIT) is treated as a bad status.
- Status from both channels in the same cycle: both are evaluated; if both are bad, the S2MM byte is latched.

Test Plan:
- **Basic capture.** Reset, enable=1, DataMover model acks with status 8'h80|tag. Expect S2MM addr sequence 0x0000, 0x1000, 0x2000…; tag 0,1,2…; btt 0x001000; fill 1,2,3.
- **Ring full.** Run with no rd_req until fill=16. Expect full_stall=1, no 17th S2MM command, and tvalid low for ≥100 cycles.
- **Wrap and readback.** From full, pulse rd_req 16 times, each after the previous status. Expect MM2S addrs 0x0000..0xF000 and fill decreasing to 0. S2MM resumes at addr 0x0000 with tag 0 once fill=15.
- **Coincident commit and retire.** Return S2MM and MM2S status in the same cycle with fill=5. Expect fill stays 5, wr_seg and rd_seg each advance by 1.
- **Dropped request.** rd_req at fill=0, then rd_req while rd_busy=1. Expect no MM2S command issued for either.
- **Error.** Return S2MM status 8'h40|tag (SLVERR). Expect err=1, err_status=that byte, no further commands on either channel, fill frozen. After reset: err=0, fill=0, first command addr 0x0000.

Source files
------------

// File: rtl/ddr_ring_sched_if.sv
// DataMover command/status bundle for ddr_ring_sched.
// master: scheduler side (drives commands, status tready, aresetn).
// slave:  DataMover side (accepts commands, returns status bytes).
interface ddr_ring_sched_if;
  // S2MM (capture into DDR)
  logic        m_axis_s2mm_cmdsts_aresetn;
  logic [71:0] S_AXIS_S2MM_CMD_tdata;
  logic        S_AXIS_S2MM_CMD_tvalid;
  logic        S_AXIS_S2MM_CMD_tready;
  logic [7:0]  M_AXIS_S2MM_STS_tdata;
  logic        M_AXIS_S2MM_STS_tvalid;
  logic        M_AXIS_S2MM_STS_tready;
  // MM2S (readback from DDR)
  logic        m_axis_mm2s_cmdsts_aresetn;
  logic [71:0] S_AXIS_MM2S_CMD_tdata;
  logic        S_AXIS_MM2S_CMD_tvalid;
  logic        S_AXIS_MM2S_CMD_tready;
  logic [7:0]  M_AXIS_MM2S_STS_tdata;
  logic        M_AXIS_MM2S_STS_tvalid;
  logic        M_AXIS_MM2S_STS_tready;

  modport master (
    output m_axis_s2mm_cmdsts_aresetn,
    output S_AXIS_S2MM_CMD_tdata,
    output S_AXIS_S2MM_CMD_tvalid,
    input  S_AXIS_S2MM_CMD_tready,
    input  M_AXIS_S2MM_STS_tdata,
    input  M_AXIS_S2MM_STS_tvalid,
    output M_AXIS_S2MM_STS_tready,
    output m_axis_mm2s_cmdsts_aresetn,
    output S_AXIS_MM2S_CMD_tdata,
    output S_AXIS_MM2S_CMD_tvalid,
    input  S_AXIS_MM2S_CMD_tready,
    input  M_AXIS_MM2S_STS_tdata,
    input  M_AXIS_MM2S_STS_tvalid,
    output M_AXIS_MM2S_STS_tready
  );

  modport slave (
    input  m_axis_s2mm_cmdsts_aresetn,
    input  S_AXIS_S2MM_CMD_tdata,
    input  S_AXIS_S2MM_CMD_tvalid,
    output S_AXIS_S2MM_CMD_tready,
    output M_AXIS_S2MM_STS_tdata,
    output M_AXIS_S2MM_STS_tvalid,
    input  M_AXIS_S2MM_STS_tready,
    input  m_axis_mm2s_cmdsts_aresetn,
    input  S_AXIS_MM2S_CMD_tdata,
    input  S_AXIS_MM2S_CMD_tvalid,
    output S_AXIS_MM2S_CMD_tready,
    output M_AXIS_MM2S_STS_tdata,
    output M_AXIS_MM2S_STS_tvalid,
    input  M_AXIS_MM2S_STS_tready
  );
endinterface

// File: rtl/ddr_ring_sched.sv
// Ring-buffer scheduler for the AXI DataMover: streams capture into NUM_SEG
// fixed-size DDR segments (S2MM) and reads back the oldest committed segment
// on request (MM2S). Tracks occupancy and halts on any DataMover error.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   enable         keep issuing S2MM segments while 1
//   rd_req         one-cycle pulse: read out the oldest committed segment
//   dm             DataMover command/status channels (master side)
//   fill           committed, unread segments
//   rd_busy        MM2S transfer in flight
//   full_stall     S2MM held off because the ring is full
//   err/err_status sticky error flag and first failing status byte
module ddr_ring_sched #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned SEG_BYTES = 4096,
  parameter int unsigned NUM_SEG   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       rd_req,
  ddr_ring_sched_if.master           dm,
  output logic [$clog2(NUM_SEG):0]   fill,
  output logic                       rd_busy,
  output logic                       full_stall,
  output logic                       err,
  output logic [7:0]                 err_status
);

  localparam int unsigned SEG_W  = $clog2(NUM_SEG);
  localparam int unsigned FILL_W = SEG_W + 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(NUM_SEG);
  localparam logic [22:0]       BTT      = 23'(SEG_BYTES);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_CMD  = 2'd1;
  localparam logic [1:0] W_WAIT = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_CMD  = 2'd1;
  localparam logic [1:0] R_WAIT = 2'd2;

  // DataMover command word for one segment; tag is the low segment bits.
  function automatic logic [71:0] make_cmd(input logic [SEG_W-1:0] seg);
    logic [31:0] addr;
    addr = BASE_ADDR + 32'(seg) * 32'(SEG_BYTES);
    return {4'h0, 4'(seg), addr, 8'h00, 1'b1, BTT};
  endfunction

  // Good status: OKAY set, no error bits, tag matches the outstanding command.
  function automatic logic sts_ok(input logic [7:0] sts, input logic [3:0] tag);
    return sts[7] && (sts[6:4] == 3'b000) && (sts[3:0] == tag);
  endfunction

  logic [1:0]        w_state, w_state_nxt;
  logic [1:0]        r_state, r_state_nxt;
  logic [SEG_W-1:0]  wr_seg, wr_seg_nxt;
  logic [SEG_W-1:0]  rd_seg, rd_seg_nxt;
  logic [FILL_W-1:0] fill_nxt;
  logic              err_nxt;
  logic [7:0]        err_status_nxt;
  logic              rd_busy_nxt, full_stall_nxt;

  logic [71:0]       s2mm_tdata, s2mm_tdata_nxt;
  logic              s2mm_tvalid, s2mm_tvalid_nxt;
  logic [71:0]       mm2s_tdata, mm2s_tdata_nxt;
  logic              mm2s_tvalid, mm2s_tvalid_nxt;
  logic              s2mm_sts_rdy, mm2s_sts_rdy;
  logic              s2mm_rstn, mm2s_rstn;

  logic              w_sts_fire, w_sts_good, w_sts_bad;
  logic              r_sts_fire, r_sts_good, r_sts_bad;

  // Next-state and datapath for both channels, occupancy and error latch.
  always_comb begin
    w_state_nxt     = w_state;
    r_state_nxt     = r_state;
    wr_seg_nxt      = wr_seg;
    rd_seg_nxt      = rd_seg;
    fill_nxt        = fill;
    err_nxt         = err;
    err_status_nxt  = err_status;
    s2mm_tdata_nxt  = s2mm_tdata;
    s2mm_tvalid_nxt = s2mm_tvalid;
    mm2s_tdata_nxt  = mm2s_tdata;
    mm2s_tvalid_nxt = mm2s_tvalid;

    // A status outside WAIT is stray and counts as bad.
    w_sts_fire = dm.M_AXIS_S2MM_STS_tvalid && s2mm_sts_rdy;
    r_sts_fire = dm.M_AXIS_MM2S_STS_tvalid && mm2s_sts_rdy;
    w_sts_good = w_sts_fire && (w_state == W_WAIT)
                 && sts_ok(dm.M_AXIS_S2MM_STS_tdata, 4'(wr_seg));
    r_sts_good = r_sts_fire && (r_state == R_WAIT)
                 && sts_ok(dm.M_AXIS_MM2S_STS_tdata, 4'(rd_seg));
    w_sts_bad  = w_sts_fire && !w_sts_good;
    r_sts_bad  = r_sts_fire && !r_sts_good;

    // S2MM: write segments while there is room.
    case (w_state)
      W_IDLE: begin
        if (enable && (fill < FILL_MAX) && !err) begin
          w_state_nxt     = W_CMD;
          s2mm_tdata_nxt  = make_cmd(wr_seg);
          s2mm_tvalid_nxt = 1'b1;
        end
      end
      W_CMD: begin
        if (s2mm_tvalid && dm.S_AXIS_S2MM_CMD_tready) begin
          s2mm_tvalid_nxt = 1'b0;
          w_state_nxt     = W_WAIT;
        end
      end
      W_WAIT: begin
        if (w_sts_good) begin
          wr_seg_nxt  = wr_seg + SEG_W'(1);
          w_state_nxt = W_IDLE;
        end
      end
      default: begin
        w_state_nxt     = W_IDLE;
        s2mm_tvalid_nxt = 1'b0;
      end
    endcase

    // MM2S: one read per request; requests while busy or empty are dropped.
    case (r_state)
      R_IDLE: begin
        if (rd_req && (fill != '0) && !err) begin
          r_state_nxt     = R_CMD;
          mm2s_tdata_nxt  = make_cmd(rd_seg);
          mm2s_tvalid_nxt = 1'b1;
        end
      end
      R_CMD: begin
        if (mm2s_tvalid && dm.S_AXIS_MM2S_CMD_tready) begin
          mm2s_tvalid_nxt = 1'b0;
          r_state_nxt     = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_sts_good) begin
          rd_seg_nxt  = rd_seg + SEG_W'(1);
          r_state_nxt = R_IDLE;
        end
      end
      default: begin
        r_state_nxt     = R_IDLE;
        mm2s_tvalid_nxt = 1'b0;
      end
    endcase

    // A segment under readback stays counted until its status returns.
    case ({w_sts_good, r_sts_good})
      2'b10:   fill_nxt = fill + FILL_W'(1);
      2'b01:   fill_nxt = fill - FILL_W'(1);
      default: fill_nxt = fill;
    endcase

    // Any bad status freezes the ring; the S2MM byte wins a tie.
    if (w_sts_bad || r_sts_bad) begin
      w_state_nxt     = W_IDLE;
      r_state_nxt     = R_IDLE;
      s2mm_tvalid_nxt = 1'b0;
      mm2s_tvalid_nxt = 1'b0;
      wr_seg_nxt      = wr_seg;
      rd_seg_nxt      = rd_seg;
      fill_nxt        = fill;
      err_nxt         = 1'b1;
      if (!err) begin
        err_status_nxt = w_sts_bad ? dm.M_AXIS_S2MM_STS_tdata
                                   : dm.M_AXIS_MM2S_STS_tdata;
      end
    end

    rd_busy_nxt    = (r_state_nxt != R_IDLE);
    full_stall_nxt = (w_state_nxt == W_IDLE) && enable && (fill_nxt == FILL_MAX);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state      <= W_IDLE;
      r_state      <= R_IDLE;
      wr_seg       <= '0;
      rd_seg       <= '0;
      fill         <= '0;
      err          <= 1'b0;
      err_status   <= '0;
      rd_busy      <= 1'b0;
      full_stall   <= 1'b0;
      s2mm_tdata   <= '0;
      s2mm_tvalid  <= 1'b0;
      mm2s_tdata   <= '0;
      mm2s_tvalid  <= 1'b0;
      s2mm_sts_rdy <= 1'b0;
      mm2s_sts_rdy <= 1'b0;
      s2mm_rstn    <= 1'b0;
      mm2s_rstn    <= 1'b0;
    end else begin
      w_state      <= w_state_nxt;
      r_state      <= r_state_nxt;
      wr_seg       <= wr_seg_nxt;
      rd_seg       <= rd_seg_nxt;
      fill         <= fill_nxt;
      err          <= err_nxt;
      err_status   <= err_status_nxt;
      rd_busy      <= rd_busy_nxt;
      full_stall   <= full_stall_nxt;
      s2mm_tdata   <= s2mm_tdata_nxt;
      s2mm_tvalid  <= s2mm_tvalid_nxt;
      mm2s_tdata   <= mm2s_tdata_nxt;
      mm2s_tvalid  <= mm2s_tvalid_nxt;
      s2mm_sts_rdy <= 1'b1;
      mm2s_sts_rdy <= 1'b1;
      s2mm_rstn    <= 1'b1;
      mm2s_rstn    <= 1'b1;
    end
  end

  assign dm.S_AXIS_S2MM_CMD_tdata      = s2mm_tdata;
  assign dm.S_AXIS_S2MM_CMD_tvalid     = s2mm_tvalid;
  assign dm.M_AXIS_S2MM_STS_tready     = s2mm_sts_rdy;
  assign dm.m_axis_s2mm_cmdsts_aresetn = s2mm_rstn;
  assign dm.S_AXIS_MM2S_CMD_tdata      = mm2s_tdata;
  assign dm.S_AXIS_MM2S_CMD_tvalid     = mm2s_tvalid;
  assign dm.M_AXIS_MM2S_STS_tready     = mm2s_sts_rdy;
  assign dm.m_axis_mm2s_cmdsts_aresetn = mm2s_rstn;

endmodule

// File: tb/tb_ddr_ring_sched.sv
// Self-checking bench for ddr_ring_sched: a DataMover model whose command
// monitor pops expected command words from per-channel queues; the stimulus
// process pushes expectations, drives requests and returns status bytes.
module tb_ddr_ring_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       rd_req = 1'b0;
  logic [4:0] fill;
  logic       rd_busy, full_stall, err;
  logic [7:0] err_status;

  ddr_ring_sched_if dm ();

  ddr_ring_sched #(
    .BASE_ADDR (32'h0000_0000),
    .SEG_BYTES (4096),
    .NUM_SEG   (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .rd_req     (rd_req),
    .dm         (dm),
    .fill       (fill),
    .rd_busy    (rd_busy),
    .full_stall (full_stall),
    .err        (err),
    .err_status (err_status)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int s2mm_cnt = 0;
  int mm2s_cnt = 0;
  logic [71:0] exp_s2mm[$];
  logic [71:0] exp_mm2s[$];

  // Expected command for a segment: 4 KiB segments from address 0, btt 0x1000.
  function automatic logic [71:0] cmd_of(input int seg);
    logic [31:0] a;
    logic [3:0]  t;
    a = 32'(seg) * 32'h0000_1000;
    t = 4'(seg);
    return {4'h0, t, a, 8'h00, 1'b1, 23'h001000};
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Command monitor: every accepted command must match the next expectation.
  always @(negedge clk) begin
    if (dm.S_AXIS_S2MM_CMD_tvalid === 1'b1 && dm.S_AXIS_S2MM_CMD_tready === 1'b1) begin
      s2mm_cnt++;
      if (exp_s2mm.size() == 0) begin
        checks++; errors++;
        $display("FAIL s2mm_unexpected_cmd: got %0h, expected none", dm.S_AXIS_S2MM_CMD_tdata);
      end else begin
        check("s2mm_cmd", dm.S_AXIS_S2MM_CMD_tdata, exp_s2mm.pop_front());
      end
    end
    if (dm.S_AXIS_MM2S_CMD_tvalid === 1'b1 && dm.S_AXIS_MM2S_CMD_tready === 1'b1) begin
      mm2s_cnt++;
      if (exp_mm2s.size() == 0) begin
        checks++; errors++;
        $display("FAIL mm2s_unexpected_cmd: got %0h, expected none", dm.S_AXIS_MM2S_CMD_tdata);
      end else begin
        check("mm2s_cmd", dm.S_AXIS_MM2S_CMD_tdata, exp_mm2s.pop_front());
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_s2mm_next(input string name);
    int prev = s2mm_cnt;
    int k = 0;
    while (s2mm_cnt == prev && k < 300) begin tick(); k++; end
    if (s2mm_cnt == prev) begin
      checks++; errors++;
      $display("FAIL %s: got no S2MM command, expected one within 300 cycles", name);
    end
  endtask

  task automatic wait_mm2s_next(input string name);
    int prev = mm2s_cnt;
    int k = 0;
    while (mm2s_cnt == prev && k < 300) begin tick(); k++; end
    if (mm2s_cnt == prev) begin
      checks++; errors++;
      $display("FAIL %s: got no MM2S command, expected one within 300 cycles", name);
    end
  endtask

  task automatic s2mm_sts(input logic [7:0] b);
    dm.M_AXIS_S2MM_STS_tdata  = b;
    dm.M_AXIS_S2MM_STS_tvalid = 1'b1;
    tick();
    dm.M_AXIS_S2MM_STS_tvalid = 1'b0;
  endtask

  task automatic mm2s_sts(input logic [7:0] b);
    dm.M_AXIS_MM2S_STS_tdata  = b;
    dm.M_AXIS_MM2S_STS_tvalid = 1'b1;
    tick();
    dm.M_AXIS_MM2S_STS_tvalid = 1'b0;
  endtask

  task automatic pulse_rd();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    rd_req = 1'b0;
    tick(3);
    check("rst_s2mm_tvalid", 72'(dm.S_AXIS_S2MM_CMD_tvalid), 72'd0);
    check("rst_s2mm_tdata", dm.S_AXIS_S2MM_CMD_tdata, 72'd0);
    check("rst_mm2s_tvalid", 72'(dm.S_AXIS_MM2S_CMD_tvalid), 72'd0);
    check("rst_mm2s_tdata", dm.S_AXIS_MM2S_CMD_tdata, 72'd0);
    check("rst_sts_tready", 72'({dm.M_AXIS_S2MM_STS_tready, dm.M_AXIS_MM2S_STS_tready}), 72'd0);
    check("rst_aresetn", 72'({dm.m_axis_s2mm_cmdsts_aresetn, dm.m_axis_mm2s_cmdsts_aresetn}), 72'd0);
    check("rst_fill", 72'(fill), 72'd0);
    check("rst_err", 72'({err, err_status}), 72'd0);
    check("rst_busy_stall", 72'({rd_busy, full_stall}), 72'd0);
    reset = 1'b0;
    tick();
    check("post_rst_aresetn", 72'({dm.m_axis_s2mm_cmdsts_aresetn, dm.m_axis_mm2s_cmdsts_aresetn}), 72'd3);
    check("post_rst_sts_tready", 72'({dm.M_AXIS_S2MM_STS_tready, dm.M_AXIS_MM2S_STS_tready}), 72'd3);
  endtask

  initial begin
    int hi;
    int s_before;
    int m_before;
    dm.S_AXIS_S2MM_CMD_tready = 1'b0;
    dm.S_AXIS_MM2S_CMD_tready = 1'b1;
    dm.M_AXIS_S2MM_STS_tdata  = 8'h00;
    dm.M_AXIS_S2MM_STS_tvalid = 1'b0;
    dm.M_AXIS_MM2S_STS_tdata  = 8'h00;
    dm.M_AXIS_MM2S_STS_tvalid = 1'b0;

    do_reset();

    // Basic capture until full; first command sees backpressure.
    for (int k = 0; k < 16; k++) exp_s2mm.push_back(cmd_of(k));
    enable = 1'b1;
    tick(4);
    check("s2mm_hold_tvalid", 72'(dm.S_AXIS_S2MM_CMD_tvalid), 72'd1);
    check("s2mm_hold_tdata", dm.S_AXIS_S2MM_CMD_tdata, cmd_of(0));
    dm.S_AXIS_S2MM_CMD_tready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wait_s2mm_next("s2mm_fill_cmd");
      s2mm_sts(8'h80 | 8'(k));
      check("fill_up", 72'(fill), 72'(k + 1));
    end
    tick(2);
    check("full_stall", 72'(full_stall), 72'd1);
    hi = 0;
    repeat (120) begin
      tick();
      if (dm.S_AXIS_S2MM_CMD_tvalid !== 1'b0) hi++;
    end
    check("full_no_tvalid_cycles", 72'(hi), 72'd0);
    check("full_s2mm_count", 72'(s2mm_cnt), 72'd16);

    // Wrap and readback; S2MM resumes at segment 0 once one slot frees.
    exp_s2mm.push_back(cmd_of(0));
    for (int i = 0; i < 16; i++) begin
      exp_mm2s.push_back(cmd_of(i));
      pulse_rd();
      wait_mm2s_next("mm2s_read_cmd");
      mm2s_sts(8'h80 | 8'(i));
      if (i == 0) begin
        wait_s2mm_next("s2mm_resume_cmd");
        enable = 1'b0;
      end
      check("fill_down", 72'(fill), 72'(15 - i));
    end
    check("drain_rd_busy", 72'(rd_busy), 72'd0);

    // Request at fill == 0 is dropped.
    pulse_rd();
    tick(20);
    check("drop_empty_count", 72'(mm2s_cnt), 72'd16);
    check("drop_empty_busy", 72'(rd_busy), 72'd0);

    // Retire the resumed write of segment 0, then fill to 5.
    s2mm_sts(8'h80);
    check("fill_after_resume", 72'(fill), 72'd1);
    for (int k = 1; k <= 5; k++) exp_s2mm.push_back(cmd_of(k));
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wait_s2mm_next("s2mm_refill_cmd");
      s2mm_sts(8'h80 | 8'(k));
    end
    check("fill_five", 72'(fill), 72'd5);

    // Coincident commit (seg 5) and retire (seg 0); a request while busy is dropped.
    wait_s2mm_next("s2mm_seg5_cmd");
    enable = 1'b0;
    exp_mm2s.push_back(cmd_of(0));
    pulse_rd();
    wait_mm2s_next("mm2s_seg0_cmd");
    check("busy_in_flight", 72'(rd_busy), 72'd1);
    pulse_rd();
    tick(5);
    dm.M_AXIS_S2MM_STS_tdata  = 8'h85;
    dm.M_AXIS_MM2S_STS_tdata  = 8'h80;
    dm.M_AXIS_S2MM_STS_tvalid = 1'b1;
    dm.M_AXIS_MM2S_STS_tvalid = 1'b1;
    tick();
    dm.M_AXIS_S2MM_STS_tvalid = 1'b0;
    dm.M_AXIS_MM2S_STS_tvalid = 1'b0;
    check("coincident_fill", 72'(fill), 72'd5);
    tick(10);
    check("drop_busy_count", 72'(mm2s_cnt), 72'd17);

    // Both pointers advanced: next read is seg 1, next write is seg 6.
    exp_mm2s.push_back(cmd_of(1));
    pulse_rd();
    wait_mm2s_next("mm2s_seg1_cmd");
    mm2s_sts(8'h81);
    check("fill_after_read1", 72'(fill), 72'd4);
    exp_s2mm.push_back(cmd_of(6));
    enable = 1'b1;
    wait_s2mm_next("s2mm_seg6_cmd");
    enable = 1'b0;
    s2mm_sts(8'h86);
    check("fill_after_write6", 72'(fill), 72'd5);

    // SLVERR on S2MM: sticky error, everything frozen.
    exp_s2mm.push_back(cmd_of(7));
    enable = 1'b1;
    wait_s2mm_next("s2mm_seg7_cmd");
    s2mm_sts(8'h47);
    check("err_set", 72'(err), 72'd1);
    check("err_status", 72'(err_status), 72'h47);
    check("err_fill_frozen", 72'(fill), 72'd5);
    s_before = s2mm_cnt;
    m_before = mm2s_cnt;
    pulse_rd();
    tick(50);
    check("err_no_s2mm", 72'(s2mm_cnt), 72'(s_before));
    check("err_no_mm2s", 72'(mm2s_cnt), 72'(m_before));
    check("err_rd_busy", 72'(rd_busy), 72'd0);
    mm2s_sts(8'h30);
    check("err_status_first_only", 72'(err_status), 72'h47);
    check("err_fill_still", 72'(fill), 72'd5);

    // Reset clears the error and the ring restarts at segment 0.
    do_reset();
    check("reset_err_clear", 72'(err), 72'd0);
    exp_s2mm.push_back(cmd_of(0));
    enable = 1'b1;
    wait_s2mm_next("s2mm_after_reset_cmd");
    enable = 1'b0;
    s2mm_sts(8'h80);
    check("fill_after_reset", 72'(fill), 72'd1);
    tick(5);
    check("queues_drained", 72'(exp_s2mm.size() + exp_mm2s.size()), 72'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
